// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: multi-master AHB arbiter.
// Shares one AHB address/data path among HMAS_NUM masters. Produces a one-hot
// hgrant, the hmaster index that steers the address/write-data muxes, and
// hmastlock. Grants rotate round-robin, are held across fixed-length bursts
// until the last beat is in flight, and are frozen while the granted master
// holds hlock.
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority (lowest requesting index wins); burst and lock rules are unchanged.
module ahb_bus_arbiter #(
    parameter int HMAS_NUM     = 5,
    parameter int HBURST_WIDTH = 3,
    parameter int DEF_MASTER   = 0,
    parameter int HMID_WIDTH   = $clog2(HMAS_NUM)
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [HMAS_NUM-1:0]     hbusreq,
    input  logic [HMAS_NUM-1:0]     hlock,
    input  logic [1:0]              htrans,
    input  logic [HBURST_WIDTH-1:0] hburst,
    input  logic                    hready,
    output logic [HMAS_NUM-1:0]     hgrant,
    output logic [HMID_WIDTH-1:0]   hmaster,
    output logic                    hmastlock
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [HBURST_WIDTH-1:0] HBURST_WRAP4  = HBURST_WIDTH'(3'd2);
    localparam logic [HBURST_WIDTH-1:0] HBURST_INCR4  = HBURST_WIDTH'(3'd3);
    localparam logic [HBURST_WIDTH-1:0] HBURST_WRAP8  = HBURST_WIDTH'(3'd4);
    localparam logic [HBURST_WIDTH-1:0] HBURST_INCR8  = HBURST_WIDTH'(3'd5);
    localparam logic [HBURST_WIDTH-1:0] HBURST_WRAP16 = HBURST_WIDTH'(3'd6);
    localparam logic [HBURST_WIDTH-1:0] HBURST_INCR16 = HBURST_WIDTH'(3'd7);

    localparam logic [HMID_WIDTH-1:0] DEF_IDX = HMID_WIDTH'(DEF_MASTER);

    // Expand a master index into its one-hot grant vector.
    function automatic logic [HMAS_NUM-1:0] idx_to_onehot(input logic [HMID_WIDTH-1:0] idx);
        logic [HMAS_NUM-1:0] vec;
        vec      = {HMAS_NUM{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    localparam logic [HMAS_NUM-1:0] DEF_GRANT = idx_to_onehot(DEF_IDX);

    logic [HMAS_NUM-1:0]   hgrant_r;
    logic [HMID_WIDTH-1:0] grant_idx_r;
    logic [HMID_WIDTH-1:0] hmaster_r;
    logic                  hmastlock_r;
    logic [3:0]            beat_cnt_r;
    logic [3:0]            next_cnt_s;
    logic                  rearb_ok_s;
    logic [HMID_WIDTH-1:0] winner_s;
    logic                  found_s;
`ifndef ARB_FIXED_PRIO_EN
    logic [HMID_WIDTH-1:0] rr_ptr_r;
    logic [HMID_WIDTH:0]   cand_s;
`endif

    assign hgrant    = hgrant_r;
    assign hmaster   = hmaster_r;
    assign hmastlock = hmastlock_r;

    // Beats still owed by the current burst once this transfer is accepted.
    always_comb begin
        next_cnt_s = 4'd0;
        case (htrans)
            HTRANS_IDLE: begin
                next_cnt_s = 4'd0;
            end
            HTRANS_BUSY: begin
                next_cnt_s = beat_cnt_r;
            end
            HTRANS_NONSEQ: begin
                case (hburst)
                    HBURST_WRAP4, HBURST_INCR4:   next_cnt_s = 4'd3;
                    HBURST_WRAP8, HBURST_INCR8:   next_cnt_s = 4'd7;
                    HBURST_WRAP16, HBURST_INCR16: next_cnt_s = 4'd15;
                    default:                      next_cnt_s = 4'd0;
                endcase
            end
            HTRANS_SEQ: begin
                if (beat_cnt_r != 4'd0) begin
                    next_cnt_s = beat_cnt_r - 4'd1;
                end else begin
                    next_cnt_s = 4'd0;
                end
            end
            default: begin
                next_cnt_s = 4'd0;
            end
        endcase
    end

    // The grant may move only on the last-but-one beat or later, and never under lock.
    always_comb begin
        if ((next_cnt_s <= 4'd1) && (hlock[grant_idx_r] == 1'b0)) begin
            rearb_ok_s = 1'b1;
        end else begin
            rearb_ok_s = 1'b0;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: lowest requesting index wins, default master when idle.
    always_comb begin
        winner_s = DEF_IDX;
        found_s  = 1'b0;
        for (int i = 0; i < HMAS_NUM; i++) begin
            if (!found_s && hbusreq[i]) begin
                winner_s = HMID_WIDTH'(i);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end
`else
    // Round-robin: scan from the master after the last winner, wrapping around.
    always_comb begin
        winner_s = DEF_IDX;
        found_s  = 1'b0;
        cand_s   = {(HMID_WIDTH+1){1'b0}};
        for (int i = 1; i <= HMAS_NUM; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (HMID_WIDTH+1)'(i);
            if (cand_s >= (HMID_WIDTH+1)'(HMAS_NUM)) begin
                cand_s = cand_s - (HMID_WIDTH+1)'(HMAS_NUM);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && hbusreq[cand_s[HMID_WIDTH-1:0]]) begin
                winner_s = cand_s[HMID_WIDTH-1:0];
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Remember the last real requester that won so the next scan starts after it.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_ptr_r <= DEF_IDX;
        end else if (hready && rearb_ok_s && hbusreq[winner_s]) begin
            rr_ptr_r <= winner_s;
        end
    end
`endif

    // Grant, address-phase ownership and burst tracking advance on accepted transfers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant_r    <= DEF_GRANT;
            grant_idx_r <= DEF_IDX;
            hmaster_r   <= DEF_IDX;
            hmastlock_r <= 1'b0;
            beat_cnt_r  <= 4'd0;
        end else if (hready) begin
            beat_cnt_r  <= next_cnt_s;
            hmaster_r   <= grant_idx_r;
            hmastlock_r <= hlock[grant_idx_r];
            if (rearb_ok_s) begin
                grant_idx_r <= winner_s;
                hgrant_r    <= idx_to_onehot(winner_s);
            end
        end
    end

endmodule
